// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: WIDTH-bit adder that time-multiplexes one external
// combinational 2-bit adder slice, two bits per clock, LSB pair first.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds a registered signed
// overflow flag (ovf) computed from the operand MSBs latched at start.
//
// state | meaning
// IDLE  | waiting for start; slice inputs held at 0
// RUN   | one operand bit pair per cycle through the slice
// DONE  | one-cycle done pulse; sum/cout final
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             slice_a0,
  output logic             slice_b0,
  output logic             slice_a1,
  output logic             slice_b1,
  output logic             slice_c0,
  input  logic             slice_s0,
  input  logic             slice_s1,
  input  logic             slice_c2
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH/2) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH/2 - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_next;
`ifdef SERIAL_ADDER_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // Operands shift out to zero and carry is cleared on leaving RUN, so the
  // slice drive is plain register outputs that read 0 outside RUN.
  assign slice_a0 = op_a[0];
  assign slice_a1 = op_a[1];
  assign slice_b0 = op_b[0];
  assign slice_b1 = op_b[1];
  assign slice_c0 = carry;

  // New slice bit pair enters at the MSB end; written as a shift so WIDTH=2 is legal.
  assign sum_next = WIDTH'({slice_s1, slice_s0, sum} >> 2);

  // Sequencer FSM with registered busy/done and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            ovf   <= 1'b0;
`endif
          end
        end
        RUN: begin
          sum  <= sum_next;
          op_a <= op_a >> 2;
          op_b <= op_b >> 2;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
            done  <= 1'b1;
            cout  <= slice_c2;
            carry <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            // slice_s1 lands in sum[WIDTH-1] on this final capture.
            ovf   <= (a_msb == b_msb) && (slice_s1 != a_msb);
`endif
          end else begin
            carry <= slice_c2;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH=8): behavioural 2-bit slice model,
// queue scoreboard fed by stimulus, negedge monitor popping on done.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic         slice_a0, slice_b0, slice_a1, slice_b1, slice_c0;
  logic         slice_s0, slice_s1, slice_c2;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .slice_a0(slice_a0), .slice_b0(slice_b0), .slice_a1(slice_a1),
    .slice_b1(slice_b1), .slice_c0(slice_c0),
    .slice_s0(slice_s0), .slice_s1(slice_s1), .slice_c2(slice_c2)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  // Behavioural model of the external 2-bit adder slice.
  logic [2:0] slice_res;
  assign slice_res = {1'b0, slice_a1, slice_a0} + {1'b0, slice_b1, slice_b0} + {2'b00, slice_c0};
  assign slice_s0 = slice_res[0];
  assign slice_s1 = slice_res[1];
  assign slice_c2 = slice_res[2];

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse, checks pulse shape.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1) begin
        n_done++;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sum", 32'(sum), 32'(e.s));
          check("cout", 32'(cout), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
          check("ovf", 32'(ovf), 32'(e.o));
`endif
          check("busy_in_done", 32'(busy), 32'd1);
        end
      end
      if (prev_done === 1'b1) begin
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_drop_after_done", 32'(busy), 32'd0);
      end
    end
    prev_done <= done;
  end

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) check({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic do_add(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    wait_idle("pre_idle");
    start = 1'b1; a = va; b = vb; cin = vc;
    sb.push_back('{s: es, c: ec, o: eo});
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("sum_cleared", 32'(sum), 32'd0);
    check("slice_c0_loaded", 32'(slice_c0), 32'(vc));
    check("slice_a0_loaded", 32'(slice_a0), 32'(va[0]));
    wait_idle("op_done");
    repeat (2) @(negedge clk);
    check("sum_held", 32'(sum), 32'(es));
    check("cout_held", 32'(cout), 32'(ec));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_slices", 32'({slice_a0, slice_b0, slice_a1, slice_b1, slice_c0}), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;

    do_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_add(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

    // Reset during the second RUN cycle discards the operation.
    wait_idle("rst_pre");
    start = 1'b1; a = 8'h33; b = 8'h11; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_slices", 32'({slice_a0, slice_b0, slice_a1, slice_b1, slice_c0}), 32'd0);
    repeat (8) @(negedge clk);
    check("midrst_no_done", 32'(n_done), 32'd3);
    do_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    // start held high through RUN/DONE with new operands.
    wait_idle("hold_pre");
    start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
    sb.push_back('{s: 8'h03, c: 1'b0, o: 1'b0});
    @(posedge clk); #1;
    a = 8'hFF; b = 8'hFF;
    sb.push_back('{s: 8'hFE, c: 1'b1, o: 1'b0});
    wait_idle("hold_first");
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_second_accepted", 32'(busy), 32'd1);
    wait_idle("hold_second");
    check("hold_sum", 32'(sum), 32'h0FE);
    check("hold_cout", 32'(cout), 32'd1);

`ifdef SERIAL_ADDER_OVF_EN
    do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    do_add(8'h05, 8'hFB, 1'b0, 8'h00, 1'b1, 1'b0);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("done_count", 32'(n_done), 32'd9);
`else
    check("done_count", 32'(n_done), 32'd6);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
